// File: rtl/fp_div_iter.sv
// Single-precision floating-point divider, result = A / B, one quotient bit per clock.
// Subnormal inputs are treated as zero and the quotient is truncated toward zero.
module fp_div_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     A,
  input  logic [EXP_W+FRAC_W:0]     B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      div_by_zero,
  output logic                      invalid
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int N     = FRAC_W + 2;
  localparam int CNT_W = $clog2(N);
  localparam int EW2   = EXP_W + 2;
  localparam logic [EW2-1:0] BIAS    = EW2'(2**(EXP_W-1) - 1);
  localparam logic [EW2-1:0] EXP_MAX = EW2'(2**EXP_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [W-1:0]      a_reg, b_reg;
  logic [N-1:0]      rem, quo;
  logic [FRAC_W:0]   den;
  logic [CNT_W-1:0]  cnt;
  logic [EW2-1:0]    exp_r;

  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic              sign_q, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-1:0]      inf_res, zero_res, qnan_res, spec_res;
  logic              special, spec_inv, spec_dz;
  logic [N-2:0]      diff;
  logic              ge;
  logic [EW2-1:0]    e_init, e_norm;
  logic [FRAC_W-1:0] frac_norm;
  logic              norm_ovf, norm_unf;

  assign a_exp  = a_reg[W-2:FRAC_W];
  assign b_exp  = b_reg[W-2:FRAC_W];
  assign a_frac = a_reg[FRAC_W-1:0];
  assign b_frac = b_reg[FRAC_W-1:0];
  assign sign_q = a_reg[W-1] ^ b_reg[W-1];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);

  assign inf_res  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_res = {sign_q, {(W-1){1'b0}}};
  assign qnan_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Special-operand classification, highest priority first
  always_comb begin
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    spec_res = zero_res;
    if (a_nan || b_nan) begin
      spec_res = qnan_res;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = qnan_res;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = inf_res;
    end else if (b_inf || a_zero) begin
      spec_res = zero_res;
    end else if (b_zero) begin
      spec_res = inf_res;
      spec_dz  = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // rem < 2*den always holds, so the difference fits one bit narrower than rem
  assign ge        = (rem >= {1'b0, den});
  assign diff      = rem[N-2:0] - den;
  assign e_init    = EW2'(a_exp) - EW2'(b_exp) + BIAS;
  assign e_norm    = quo[N-1] ? exp_r : exp_r - EW2'(1);
  assign frac_norm = quo[N-1] ? quo[FRAC_W:1] : quo[FRAC_W-1:0];
  assign norm_unf  = e_norm[EW2-1] || (e_norm == '0);
  assign norm_ovf  = !e_norm[EW2-1] && (e_norm >= EXP_MAX);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      rem         <= '0;
      quo         <= '0;
      den         <= '0;
      cnt         <= '0;
      exp_r       <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg       <= A;
            b_reg       <= B;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (special) begin
            result      <= spec_res;
            invalid     <= spec_inv;
            div_by_zero <= spec_dz;
            state       <= S_DONE;
          end else begin
            rem   <= {2'b01, a_frac};
            den   <= {1'b1, b_frac};
            quo   <= '0;
            cnt   <= '0;
            exp_r <= e_init;
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          quo <= {quo[N-2:0], ge};
          rem <= ge ? {diff, 1'b0} : {rem[N-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N-1)) state <= S_NORM;
        end
        S_NORM: begin
          if (norm_ovf) begin
            result   <= inf_res;
            overflow <= 1'b1;
          end else if (norm_unf) begin
            result    <= zero_res;
            underflow <= 1'b1;
          end else begin
            result <= {sign_q, e_norm[EXP_W-1:0], frac_norm};
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: a driver queues model predictions, a monitor checks each output.
module tb_fp_div_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, div_by_zero, invalid;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edge_count = 0;
  logic prev_ov = 1'b0;
  logic rand_ready = 1'b0;

  fp_div_iter #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string what, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", what, got, want);
    end
  endtask

  // Reference: exact quotient floor(ma*2^24/mb) with integer division, then normalise
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e;
    longint ma, mb, q;
    logic s, za, zb, ia, ib, na, nb;
    logic [22:0] frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    r.flags = 4'b0000;
    r.lat = 1;
    r.acc = 0;
    if (na || nb) r.res = 32'h7FC00000;
    else if ((za && zb) || (ia && ib)) begin
      r.res = 32'h7FC00000;
      r.flags = 4'b0001;
    end
    else if (ia) r.res = {s, 31'h7F800000};
    else if (ib || za) r.res = {s, 31'h0};
    else if (zb) begin
      r.res = {s, 31'h7F800000};
      r.flags = 4'b0010;
    end else begin
      r.lat = 27;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (q >= (64'd1 << 24)) frac = 23'((q >> 1) & 64'h7FFFFF);
      else begin
        frac = 23'(q & 64'h7FFFFF);
        e = e - 1;
      end
      if (e >= 255) begin
        r.res = {s, 31'h7F800000};
        r.flags = 4'b1000;
      end else if (e <= 0) begin
        r.res = {s, 31'h0};
        r.flags = 4'b0100;
      end else r.res = {s, 8'(e), frac};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    f = 23'($urandom);
    if (sel == 0) e = 8'h00;
    else if (sel == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 1) f = '0;
    end
    else if (sel == 2) e = 8'($urandom_range(1, 20));
    else if (sel == 3) e = 8'($urandom_range(235, 254));
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    int waited;
    waited = 0;
    while (!in_ready && waited < 300) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
    end else begin
      A = a;
      B = b;
      in_valid = 1'b1;
      x = model(a, b);
      x.acc = edge_count + 1;
      sb.push_back(x);
      step();
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
    end
  endtask

  task automatic wait_out_valid();
    int waited;
    waited = 0;
    while (!out_valid && waited < 100) begin
      step();
      waited++;
    end
    checkOutput("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  // Monitor: checks every cycle the result is presented, pops on the transfer edge
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL spurious_out: got result %h, expected no output", result);
      end else begin
        if (!prev_ov) checkOutput("latency", 32'(edge_count - sb[0].acc), 32'(sb[0].lat));
        checkOutput("result", result, sb[0].res);
        checkOutput("flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'(sb[0].flags));
        if (out_ready) void'(sb.pop_front());
      end
    end
    prev_ov <= out_valid;
  end

  initial begin
    forever begin
      step();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int waited;
    #2;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    step();

    applyStimulus(32'h40C00000, 32'h40000000);
    applyStimulus(32'h3F800000, 32'h40400000);
    applyStimulus(32'h40E00000, 32'hC0000000);
    applyStimulus(32'h3F800000, 32'h00000000);
    applyStimulus(32'h00000000, 32'h00000000);
    applyStimulus(32'hFF800000, 32'h7F800000);
    applyStimulus(32'h44FC7333, 32'hFF800001);
    applyStimulus(32'h00000000, 32'h40000000);
    applyStimulus(32'h7F000000, 32'h3E800000);
    applyStimulus(32'h00800000, 32'h40800000);

    // Backpressure: result held, busy input ignored, then one transfer
    while (!in_ready) step();
    out_ready = 1'b0;
    applyStimulus(32'h40C00000, 32'h40000000);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = $urandom;
      B = $urandom;
      step();
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("post_xfer_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_xfer_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_xfer_result", result, 32'h40400000);
    checkOutput("post_xfer_queue", 32'(sb.size()), 32'd0);

    // Reset in the middle of the mantissa iterations
    applyStimulus(32'h40C00000, 32'h40400000);
    repeat (10) step();
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    step();
    rst = 1'b0;
    step();
    applyStimulus(32'h40200000, 32'h3F000000);

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(rand_fp(), rand_fp());
      repeat ($urandom_range(0, 3)) step();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;

    waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      step();
      waited++;
    end
    checkOutput("drain_queue", 32'(sb.size()), 32'd0);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
